// File: rtl/keystream_xor_cipher.sv
// Keystream word packer, FIFO and XOR stage between the LFSR and the byte datapath.
// Optional sticky drop flag o_ks_overflow is enabled by defining KSC_OVERFLOW_FLAG_EN.
module keystream_xor_cipher #(
  parameter int DATA_W   = 8,
  parameter int KS_DEPTH = 4
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_clr,
  input  logic                      i_ks_bit,
  input  logic                      i_ks_valid,
  input  logic [DATA_W-1:0]         i_data,
  input  logic                      i_data_valid,
  output logic                      o_data_ready,
  output logic [DATA_W-1:0]         o_data,
  output logic                      o_data_valid,
  input  logic                      i_data_ready,
  output logic [$clog2(KS_DEPTH):0] o_ks_level,
  output logic [15:0]               o_byte_cnt
`ifdef KSC_OVERFLOW_FLAG_EN
  ,
  output logic                      o_ks_overflow
`endif
);

  localparam int AW = $clog2(KS_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [DATA_W-2:0] sr;
  logic [DATA_W-1:0] word;
  logic [CW-1:0]     bit_cnt;
  logic [DATA_W-1:0] mem [KS_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [DATA_W-1:0] head;
  logic              word_done;
  logic              full;
  logic              xfer;
  logic              push;
  logic              pop;
  logic              drop;

  // First received bit ends up as the word MSB.
  assign word      = {sr, i_ks_bit};
  assign word_done = i_ks_valid && !i_clr
                     && (bit_cnt == CW'(DATA_W - 1));
  assign full      = (o_ks_level == LW'(KS_DEPTH));
  assign head      = mem[rd_ptr];

  assign o_data_ready = (o_ks_level != '0)
                        && (!o_data_valid || i_data_ready)
                        && !i_clr;

  assign xfer = i_data_valid && o_data_ready;
  assign pop  = xfer;
  // A pop frees the slot, so a push into a full FIFO still lands.
  assign push = word_done && (!full || pop);
  assign drop = word_done && full && !pop;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (i_clr) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (i_ks_valid) begin
      sr      <= word[DATA_W-2:0];
      bit_cnt <= word_done ? '0 : bit_cnt + CW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem[wr_ptr] <= word;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_ks_level <= '0;
    end else if (i_clr) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      o_ks_level <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        o_ks_level <= o_ks_level + LW'(1);
      end else if (pop && !push) begin
        o_ks_level <= o_ks_level - LW'(1);
      end
    end
  end

  // o_data keeps its last value across a flush; only valid drops.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_data       <= '0;
      o_data_valid <= 1'b0;
      o_byte_cnt   <= '0;
    end else if (i_clr) begin
      o_data_valid <= 1'b0;
      o_byte_cnt   <= '0;
    end else if (xfer) begin
      o_data       <= i_data ^ head;
      o_data_valid <= 1'b1;
      o_byte_cnt   <= o_byte_cnt + 16'd1;
    end else if (o_data_valid && i_data_ready) begin
      o_data_valid <= 1'b0;
    end
  end

`ifdef KSC_OVERFLOW_FLAG_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_ks_overflow <= 1'b0;
    end else if (i_clr) begin
      o_ks_overflow <= 1'b0;
    end else if (drop) begin
      o_ks_overflow <= 1'b1;
    end
  end
`else
  logic unused_drop;
  assign unused_drop = drop;
`endif

endmodule

// File: tb/tb_keystream_xor_cipher.sv
// Scoreboard bench for keystream_xor_cipher against a queue-based reference model.
// Covers directed packing, overflow, backpressure, flush, reset and random traffic.
module tb_keystream_xor_cipher;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk;
  logic         rst;
  logic         clr;
  logic         ks_bit;
  logic         ks_valid;
  logic [W-1:0] data;
  logic         data_valid;
  logic         data_ready_o;
  logic [W-1:0] o_data;
  logic         o_valid;
  logic         data_ready;
  logic [2:0]   level;
  logic [15:0]  byte_cnt;
`ifdef KSC_OVERFLOW_FLAG_EN
  logic         ovf;
`endif

  keystream_xor_cipher #(.DATA_W(W), .KS_DEPTH(D)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_clr        (clr),
    .i_ks_bit     (ks_bit),
    .i_ks_valid   (ks_valid),
    .i_data       (data),
    .i_data_valid (data_valid),
    .o_data_ready (data_ready_o),
    .o_data       (o_data),
    .o_data_valid (o_valid),
    .i_data_ready (data_ready),
    .o_ks_level   (level),
    .o_byte_cnt   (byte_cnt)
`ifdef KSC_OVERFLOW_FLAG_EN
    ,
    .o_ks_overflow(ovf)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [W-1:0] ksq[$];
  logic [W-1:0] exp_d[$];
  int           exp_c[$];
  int           nbits;
  int           acc;
  bit           mvalid;
  int           bytes;
  bit           movf;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ksq.delete();
    exp_d.delete();
    exp_c.delete();
    nbits  = 0;
    acc    = 0;
    mvalid = 0;
    bytes  = 0;
    movf   = 0;
  endtask

  // One clock: drive at posedge+1, check at negedge, update model at posedge.
  task automatic cyc(input bit kb, input bit kv, input logic [W-1:0] d,
                     input bit dv, input bit dr, input bit cl);
    bit           er;
    logic [W-1:0] h;
    ks_bit = kb; ks_valid = kv; data = d;
    data_valid = dv; data_ready = dr; clr = cl;
    @(negedge clk);
    er = (ksq.size() != 0) && (!mvalid || dr) && !cl;
    chk("ready", int'(data_ready_o), int'(er));
    chk("level", int'(level), ksq.size());
    chk("bytecnt", int'(byte_cnt), bytes);
    chk("valid", int'(o_valid), int'(mvalid));
`ifdef KSC_OVERFLOW_FLAG_EN
    chk("ovf", int'(ovf), int'(movf));
`endif
    @(posedge clk);
    if (cl) begin
      model_reset();
    end else begin
      if (dv && er) begin
        h = ksq.pop_front();
        bytes = (bytes + 1) % 65536;
        exp_d.push_back(d ^ h);
        exp_c.push_back(bytes);
        mvalid = 1;
      end else if (mvalid && dr) begin
        mvalid = 0;
      end
      if (kv) begin
        acc = ((acc * 2) + int'(kb)) % (1 << W);
        nbits++;
        if (nbits == W) begin
          nbits = 0;
          if (ksq.size() < D) ksq.push_back(W'(acc));
          else movf = 1;
        end
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, '0, 0, 1, 0);
  endtask

  task automatic feed_word(input logic [W-1:0] w);
    logic [W-1:0] t;
    t = w;
    for (int i = W - 1; i >= 0; i--) cyc(t[i], 1, '0, 0, 1, 0);
  endtask

  task automatic feed_rand(input int n);
    for (int i = 0; i < n; i++) cyc(1'($urandom), 1, '0, 0, 1, 0);
  endtask

  // Monitor: pops the scoreboard whenever an output word is consumed.
  initial begin
    logic [W-1:0] ed;
    int           ec;
    forever begin
      @(negedge clk);
      if (!rst && o_valid && data_ready) begin
        if (exp_d.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL mon_extra: got word %0h expected none", o_data);
        end else begin
          ed = exp_d.pop_front();
          ec = exp_c.pop_front();
          chk("mon_data", int'(o_data), int'(ed));
          chk("mon_cnt", int'(byte_cnt), ec);
        end
      end
    end
  end

  initial begin
    bit           b2[40];
    logic [W-1:0] wv;
    logic [W-1:0] d;
    logic [W-1:0] held;
    int           bc;
    int           lv;

    rst = 1'b1; clr = 0; ks_bit = 0; ks_valid = 0;
    data = '0; data_valid = 0; data_ready = 1;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_data", int'(o_data), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_ready", int'(data_ready_o), 0);
    chk("rst_cnt", int'(byte_cnt), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: packing 1,0,1,0,0,1,0,1 -> 0xA5, then XOR with 0xFF
    wv = 8'hA5;
    for (int i = W - 1; i >= 0; i--) begin
      cyc(wv[i], 1, '0, 0, 1, 0);
      idle(9);
    end
    chk("t1_level", int'(level), 1);
    cyc(0, 0, 8'hFF, 1, 1, 0);
    chk("t1_data", int'(o_data), 'h5A);
    chk("t1_valid", int'(o_valid), 1);
    chk("t1_cnt", int'(byte_cnt), 1);
    chk("t1_level0", int'(level), 0);
    idle(2);

    // 2: overflow, 40 strobes, 5th word dropped
    for (int i = 0; i < 40; i++) begin
      b2[i] = 1'($urandom);
      cyc(b2[i], 1, '0, 0, 1, 0);
    end
    chk("t2_level", int'(level), 4);
`ifdef KSC_OVERFLOW_FLAG_EN
    chk("t2_ovf", int'(ovf), 1);
`endif
    for (int k = 0; k < 4; k++) begin
      wv = '0;
      for (int j = 0; j < W; j++) wv = (wv << 1) | W'(b2[k * W + j]);
      d = W'($urandom);
      cyc(0, 0, d, 1, 1, 0);
      chk("t2_word", int'(o_data), int'(d ^ wv));
    end
    idle(2);

    // 3: backpressure for 5 cycles
    feed_rand(16);
    cyc(0, 0, W'($urandom), 1, 0, 0);
    held = o_data; bc = int'(byte_cnt); lv = int'(level);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, W'($urandom), 1, 0, 0);
      chk("t3_hold", int'(o_data), int'(held));
      chk("t3_cnt", int'(byte_cnt), bc);
      chk("t3_level", int'(level), lv);
      chk("t3_ready", int'(data_ready_o), 0);
    end
    cyc(0, 0, W'($urandom), 1, 1, 0);
    chk("t3_next", int'(byte_cnt), bc + 1);
    idle(2);

    // 4: back-to-back drain of a full FIFO
    cyc(0, 0, '0, 0, 1, 1);
    feed_rand(32);
    for (int k = 0; k < 4; k++) begin
      cyc(0, 0, W'($urandom), 1, 1, 0);
      chk("t4_cnt", int'(byte_cnt), k + 1);
    end
    chk("t4_ready", int'(data_ready_o), 0);
    cyc(0, 0, W'($urandom), 1, 1, 0);
    idle(2);

    // 5: push coincides with pop at level 4
    cyc(0, 0, '0, 0, 1, 1);
    feed_rand(39);
    cyc(1'($urandom), 1, W'($urandom), 1, 1, 0);
    chk("t5_level", int'(level), 4);
`ifdef KSC_OVERFLOW_FLAG_EN
    chk("t5_ovf", int'(ovf), 0);
`endif
    for (int k = 0; k < 4; k++) cyc(0, 0, W'($urandom), 1, 1, 0);
    idle(2);

    // 6: flush a partial word, then reset mid-transfer
    cyc(0, 0, '0, 0, 1, 1);
    feed_rand(5);
    cyc(1, 1, 8'hFF, 1, 1, 1);
    feed_word(8'h3C);
    chk("t6_level", int'(level), 1);
    cyc(0, 0, 8'h00, 1, 1, 0);
    chk("t6_data", int'(o_data), 'h3C);
    idle(1);
    feed_rand(8);
    cyc(0, 0, W'($urandom), 1, 0, 0);
    ks_valid = 0; data_valid = 0;
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_valid", int'(o_valid), 0);
    chk("t6_rst_data", int'(o_data), 0);
    chk("t6_rst_level", int'(level), 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      cyc(1'($urandom), ($urandom_range(0, 1) == 1), W'($urandom),
          ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 99) == 0));
    end
    idle(4);
    chk("drain", exp_d.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
